// File: rtl/wr_control_pkg.sv
// Shared definitions for the systolic-array write controller: default sizes,
// FSM state encoding and the cycle-counter width rule.
package wr_control_pkg;

  localparam int WIDTH_HEIGHT_DEFAULT    = 16;
  localparam int LANE_ADDR_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold every RUN cycle index of a 2*width_height-long run.
  function automatic int count_width(input int wh);
    return $clog2(2 * wh) + 1;
  endfunction

endpackage

// File: rtl/wr_lane_addr.sv
// One lane's write-address counter: loads the row base at start, then
// advances once per cycle in which the lane wrote, otherwise holds.
module wr_lane_addr
  import wr_control_pkg::*;
#(
  parameter int lane_addr_width = LANE_ADDR_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic [lane_addr_width-1:0] i_base,
  input  logic                       i_inc,
  output logic [lane_addr_width-1:0] o_addr
);

  logic [lane_addr_width-1:0] r_addr;

  // Natural wrap of the adder gives the modulo-2^N address space.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_inc) begin
      r_addr <= r_addr + lane_addr_width'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/wr_control.sv
// Write controller that de-skews the diagonal output of a systolic array:
// a staircase of per-lane write enables, each lane active width_height cycles.
module wr_control
  import wr_control_pkg::*;
#(
  parameter int width_height    = WIDTH_HEIGHT_DEFAULT,
  parameter int lane_addr_width = LANE_ADDR_WIDTH_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    active,
  input  logic [lane_addr_width-1:0]              base_addr,
  output logic [width_height-1:0]                 wr_en,
  output logic [width_height*lane_addr_width-1:0] wr_addr,
  output logic                                    busy,
  output logic                                    done
);

  localparam int                CNT_W     = count_width(width_height);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(width_height - 1);
  localparam logic [width_height-1:0] LANE0_ONLY = width_height'(1);

  state_t                  r_state, r_state_next;
  logic [width_height-1:0] r_wr_en, r_wr_en_next;
  logic                    r_busy, r_busy_next;
  logic                    r_done, r_done_next;
  logic [CNT_W-1:0]        r_count, r_count_next;

  logic                    w_fill;
  logic                    w_start;
  logic [width_height-1:0] w_fill_vec;
  logic [width_height-1:0] w_shifted;

  // r_count = RUN edges already taken, so lane 0 has written r_count+1 times.
  assign w_fill = (r_count < FILL_LAST);

  always_comb begin
    w_fill_vec    = '0;
    w_fill_vec[0] = w_fill;
  end

  assign w_shifted = (r_wr_en << 1) | w_fill_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr_en <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= r_state_next;
      r_wr_en <= r_wr_en_next;
      r_busy  <= r_busy_next;
      r_done  <= r_done_next;
      r_count <= r_count_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    r_wr_en_next = r_wr_en;
    r_busy_next  = r_busy;
    r_done_next  = 1'b0;
    r_count_next = r_count;
    w_start      = 1'b0;

    case (r_state)
      IDLE: begin
        r_wr_en_next = '0;
        r_busy_next  = 1'b0;
        if (active) begin
          w_start      = 1'b1;
          r_wr_en_next = LANE0_ONLY;
          r_busy_next  = 1'b1;
          r_count_next = '0;
          r_state_next = RUN;
        end
      end

      RUN: begin
        r_count_next = r_count + CNT_W'(1);
        if (w_shifted == '0) begin
          r_wr_en_next = '0;
          r_busy_next  = 1'b0;
          r_done_next  = 1'b1;
          r_state_next = DONE;
        end else begin
          r_wr_en_next = w_shifted;
        end
      end

      DONE: begin
        r_wr_en_next = '0;
        r_busy_next  = 1'b0;
        r_count_next = '0;
        r_state_next = IDLE;
      end

      default: begin
        r_wr_en_next = '0;
        r_busy_next  = 1'b0;
        r_count_next = '0;
        r_state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < width_height; gi++) begin : g_lane
      wr_lane_addr #(
        .lane_addr_width(lane_addr_width)
      ) u_lane_addr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_start),
        .i_base (base_addr),
        .i_inc  (r_wr_en[gi]),
        .o_addr (wr_addr[gi*lane_addr_width +: lane_addr_width])
      );
    end
  endgenerate

  assign wr_en = r_wr_en;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_wr_control.sv
// Randomised scoreboard bench for wr_control at width_height 16 and 4.
module tb_wr_control;

  typedef struct {
    int           cyc;
    logic [15:0]  en;
    logic [127:0] addr;
    logic         busy;
    logic         done;
    logic [7:0]   base;
  } exp_t;

  logic         clk;
  logic         rst16, act16, busy16, done16;
  logic [7:0]   base16;
  logic [15:0]  en16;
  logic [127:0] addr16;
  logic         rst4, act4, busy4, done4;
  logic [7:0]   base4;
  logic [3:0]   en4;
  logic [31:0]  addr4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   wcount[2][16][256];

  wr_control #(.width_height(16), .lane_addr_width(8)) u_dut16 (
    .clk(clk), .reset(rst16), .active(act16), .base_addr(base16),
    .wr_en(en16), .wr_addr(addr16), .busy(busy16), .done(done16)
  );

  wr_control #(.width_height(4), .lane_addr_width(8)) u_dut4 (
    .clk(clk), .reset(rst4), .active(act4), .base_addr(base4),
    .wr_en(en4), .wr_addr(addr4), .busy(busy4), .done(done4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: lane i writes base+k at run cycle i+1+k, k = 0..w-1; the
  // address of a lane is base plus the number of writes it has made so far.
  task automatic push_run(input int id, input int w, input logic [7:0] base, input int cyc0);
    for (int c = 1; c <= 2 * w; c++) begin
      exp_t e;
      e.cyc  = cyc0 + c;
      e.en   = '0;
      e.addr = '0;
      for (int i = 0; i < w; i++) begin
        int k;
        k = c - 1 - i;
        if (k < 0) k = 0;
        if (k > w) k = w;
        if (c >= i + 1 && c <= i + w) e.en[i] = 1'b1;
        e.addr[i*8 +: 8] = 8'(int'(base) + k);
      end
      e.busy = (c < 2 * w) ? 1'b1 : 1'b0;
      e.done = (c == 2 * w) ? 1'b1 : 1'b0;
      e.base = base;
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  task automatic pop_exp(input int id, output bit have, output exp_t e);
    have = 1'b0;
    e    = '{default: '0};
    if (id == 0 && q0.size() > 0) begin
      e = q0.pop_front(); have = 1'b1;
    end else if (id == 1 && q1.size() > 0) begin
      e = q1.pop_front(); have = 1'b1;
    end
  endtask

  task automatic check_dut(input int id, input int w, input logic [15:0] en,
                           input logic [127:0] addr, input logic busy, input logic done);
    exp_t e;
    bit   have;
    int   bad, total, first_lane, first_addr, first_cnt;
    if (en === 16'h0 && busy === 1'b0 && done === 1'b0) return;
    pop_exp(id, have, e);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_output dut%0d cyc %0d: got en=%h busy=%b done=%b, required no output",
               id, cyc, en, busy, done);
      return;
    end
    checks++;
    if (e.cyc != cyc || en !== e.en || busy !== e.busy || done !== e.done) begin
      errors++;
      $display("FAIL outputs dut%0d: got cyc=%0d en=%h busy=%b done=%b, required cyc=%0d en=%h busy=%b done=%b",
               id, cyc, en, busy, done, e.cyc, e.en, e.busy, e.done);
    end
    checks++;
    if (addr !== e.addr) begin
      errors++;
      $display("FAIL wr_addr dut%0d cyc %0d: got %h, required %h", id, cyc, addr, e.addr);
    end
    for (int i = 0; i < w; i++)
      if (en[i] === 1'b1) wcount[id][i][addr[i*8 +: 8]]++;
    if (e.done) begin
      bad = 0; total = 0; first_lane = 0; first_addr = 0; first_cnt = 0;
      for (int i = 0; i < w; i++) begin
        for (int a = 0; a < 256; a++) begin
          int want;
          want = (((a - int'(e.base)) & 255) < w) ? 1 : 0;
          total += wcount[id][i][a];
          if (wcount[id][i][a] != want) begin
            if (bad == 0) begin
              first_lane = i; first_addr = a; first_cnt = wcount[id][i][a];
            end
            bad++;
          end
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL lane_coverage dut%0d: %0d bad cells, lane %0d addr %h written %0d times, required each window address once",
                 id, bad, first_lane, first_addr, first_cnt);
      end
      checks++;
      if (total != w * w) begin
        errors++;
        $display("FAIL total_writes dut%0d: got %0d, required %0d", id, total, w * w);
      end
      for (int i = 0; i < 16; i++)
        for (int a = 0; a < 256; a++) wcount[id][i][a] = 0;
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, 16, en16, addr16, busy16, done16);
    check_dut(1, 4, {12'h0, en4}, {96'h0, addr4}, busy4, done4);
  end

  task automatic drive(input int id, input logic a, input logic [7:0] b);
    if (id == 0) begin act16 = a; base16 = b; end
    else         begin act4  = a; base4  = b; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input int id);
    int sz;
    sz = (id == 0) ? q0.size() : q1.size();
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL missing_output dut%0d cyc %0d: %0d expected cycles never seen, required 0", id, cyc, sz);
    end
  endtask

  task automatic check_idle(input string name, input int id);
    logic [15:0]  en;
    logic [127:0] addr;
    logic         b, d;
    en   = (id == 0) ? en16 : {12'h0, en4};
    addr = (id == 0) ? addr16 : {96'h0, addr4};
    b    = (id == 0) ? busy16 : busy4;
    d    = (id == 0) ? done16 : done4;
    checks++;
    if (en !== 16'h0 || addr !== 128'h0 || b !== 1'b0 || d !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: got en=%h addr=%h busy=%b done=%b, required all zero",
               name, id, en, addr, b, d);
    end
  endtask

  // One run; with noise, active toggles randomly while the run is in progress.
  task automatic run(input int id, input logic [7:0] base, input bit noise);
    int w;
    w = (id == 0) ? 16 : 4;
    drive(id, 1'b1, base);
    push_run(id, w, base, cyc);
    step();
    for (int k = 1; k <= 2 * w; k++) begin
      drive(id, noise ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
      step();
    end
    drive(id, 1'b0, 8'($urandom));
    check_empty(id);
    repeat ($urandom_range(0, 3)) step();
  endtask

  task automatic run_held(input int id, input logic [7:0] base);
    int w;
    w = (id == 0) ? 16 : 4;
    drive(id, 1'b1, base);
    push_run(id, w, base, cyc);
    push_run(id, w, base, cyc + 2 * w + 1);
    repeat (4 * w - 4) step();
    drive(id, 1'b0, base);
    repeat (10) step();
    check_empty(id);
  endtask

  initial begin
    rst16 = 1'b1; rst4 = 1'b1;
    act16 = 1'b1; act4 = 1'b1;
    base16 = 8'h55; base4 = 8'h33;
    repeat (3) step();
    rst16 = 1'b0; rst4 = 1'b0;
    act16 = 1'b0; act4 = 1'b0;
    check_idle("reset_state", 0);
    check_idle("reset_state", 1);
    repeat (3) step();
    check_idle("start_dropped", 0);
    check_idle("start_dropped", 1);

    run(0, 8'h10, 1'b0);
    run(0, 8'hF8, 1'b1);
    run_held(0, 8'h42);

    drive(0, 1'b1, 8'h80);
    push_run(0, 16, 8'h80, cyc);
    step();
    drive(0, 1'b0, 8'h00);
    repeat (9) step();
    rst16 = 1'b1;
    step();
    rst16 = 1'b0;
    q0.delete();
    for (int i = 0; i < 16; i++)
      for (int a = 0; a < 256; a++) wcount[0][i][a] = 0;
    check_idle("abort_state", 0);
    repeat (40) step();
    check_empty(0);
    run(0, 8'h80, 1'b0);

    for (int r = 0; r < 4; r++) run(0, 8'($urandom), 1'b1);

    run(1, 8'h00, 1'b0);
    run(1, 8'hFE, 1'b1);
    run_held(1, 8'h07);
    for (int r = 0; r < 4; r++) run(1, 8'($urandom), 1'b1);

    repeat (5) step();
    check_empty(0);
    check_empty(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_control.md
WR_CONTROL -- requirements
Module: wr_control

Interface
REQ-001 The block SHALL have parameter width_height, default 16: number of systolic-array columns, one memory lane per column.
REQ-002 The block SHALL have parameter lane_addr_width, default 8: address bits per lane.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port active, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The block SHALL have port base_addr, input, lane_addr_width bits: first output row address, latched at start.
REQ-006 The block SHALL have port wr_en, output, width_height bits: per-lane memory write enable; bit i is lane i.
REQ-007 The block SHALL have port wr_addr, output, width_height*lane_addr_width bits: per-lane write address; lane i occupies bits [i*lane_addr_width +: lane_addr_width].
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-011 IDLE: the block SHALL hold wr_en=0; on the edge sampling active=1 it SHALL load wr_en=1 (lane 0 only), all lane addresses=base_addr, busy=1, and go to RUN.
REQ-012 RUN, each edge: the block SHALL set wr_en <= (wr_en << 1) | fill; fill=1 until lane 0 has been enabled width_height cycles, then 0.
REQ-013 Each lane i SHALL be enabled for exactly width_height consecutive cycles, starting i cycles after lane 0 (de-skew of diagonal systolic output).
REQ-014 Enable SHALL be nonzero for exactly 2*width_height-1 cycles per run (31 for width_height=16).
REQ-015 A lane address SHALL increment by 1 on each edge where that lane's wr_en bit was 1; otherwise it SHALL hold its value.
REQ-016 Lane address arithmetic SHALL be modulo 2^lane_addr_width; base_addr near the top wraps to 0 without error.
REQ-017 When wr_en would become all-zero, the block SHALL enter DONE with wr_en=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
REQ-018 active SHALL be ignored in RUN and DONE; minimum start-to-start spacing is 2*width_height+1 cycles.
REQ-019 Cycle-count register SHALL be $clog2(2*width_height)+1 bits.

Reset
REQ-020 With reset=1 at an edge, the block SHALL enter IDLE with wr_en=0, all wr_addr lanes=0, busy=0, done=0, and the counter=0.
REQ-021 Reset SHALL take priority over active and over any state, including mid-RUN; no done pulse SHALL follow an aborted run.
REQ-022 With active and reset both high, reset SHALL win; the start is dropped.

Structure
REQ-023 Constants lane_addr_width default and width_height default SHALL live in the shared control package, alongside FSM state encodings IDLE/RUN/DONE.
REQ-024 The per-lane address counter (load base, increment on enable, hold) SHALL be a sub-module wr_lane_addr, instantiated width_height times by generate loop.

Verification
REQ-025 Start with base_addr=8'h10, width_height=16 -> the cycle after the start edge wr_en=16'h0001; 16'hFFFF at cycle 16; 16'h8000 at cycle 31; done=1 at cycle 32; lane 15 writes addresses 8'h10..8'h1F.
REQ-026 base_addr=8'hF8 -> each lane writes F8..FF then 00..07; no X, no carry into neighbouring lane.
REQ-027 Hold active=1 continuously -> second run wr_en=16'h0001 only after done pulse and return to IDLE, spacing 33 cycles.
REQ-028 Assert reset at cycle 10 of RUN -> next cycle wr_en=0, wr_addr=0, busy=0, and no done pulse; a subsequent start behaves as a fresh run.
REQ-029 Parameter width_height=4, base_addr=0 -> wr_en sequence 1,3,7,F,E,C,8, then done; each lane writes addresses 0..3.
REQ-030 Scoreboard check, all scenarios -> total writes per run = width_height*width_height; each (lane, address) written exactly once.
